uart_tx: RTL

//   8-N-1 UART transmitter; the transmit counterpart of the uart_rx block.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_gen.sv | 36 +++
 rtl/uart_tx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`timescale 1ns/100ps
// Shared UART definitions: FSM state encoding, data width and the baud divisor helper.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    function automatic int unsigned clks_per_bit(input int unsigned sys_clk_freq,
                                                 input int unsigned baud_rate);
        return sys_clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
`timescale 1ns/100ps
// Bit-period counter: tick_c marks the last cycle of each bit, pre_tick_c the cycle before it.
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick_c,
    output logic pre_tick_c
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counter wraps to 0 at every bit boundary; clear restarts a fresh bit period.
    always_comb begin
        tick_c     = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
        pre_tick_c = !clear && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));
        cnt_d      = cnt_q + CNT_W'(1);
        if (clear || tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
`timescale 1ns/100ps
// 8-N-1 UART transmitter with registered tx/busy/done.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE    = 115200,
    parameter int unsigned SYS_CLK_FREQ = 12000000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [UART_DATA_BITS-1:0] data_in,
    input  logic                      send,
    output logic                      tx,
    output logic                      busy,
    output logic                      done
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(SYS_CLK_FREQ, BAUD_RATE);
    localparam int unsigned BIT_CNT_W    = $clog2(UART_DATA_BITS);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("uart_tx: CLKS_PER_BIT=%0d must be >= 2", CLKS_PER_BIT);
    end

    uart_state_e                 state_q, state_d;
    logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        accept_c;
    logic                        baud_clear_c;
    logic                        tick_c;
    logic                        pre_tick_c;
`ifdef UART_TX_PARITY_EN
    logic                        parity_q, parity_d;
`endif

    // busy_q is low only in IDLE and in the final stop-bit cycle, so both accept points share this.
    assign accept_c     = send && !busy_q;
    assign baud_clear_c = (state_q == ST_IDLE) || accept_c;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk        (clk),
        .rst_n      (reset),
        .clear      (baud_clear_c),
        .tick_c     (tick_c),
        .pre_tick_c (pre_tick_c)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
        if (accept_c) begin
            parity_d = ^data_in;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_START;
                    shift_d = data_in;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tick_c) begin
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                    if (bit_cnt_q == BIT_CNT_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_c) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick_c) begin
                    if (accept_c) begin
                        state_d = ST_START;
                        shift_d = data_in;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs describe the cycle that follows, so they come from the next state.
        done_d = (state_d == ST_STOP) && pre_tick_c;
        busy_d = (state_d != ST_IDLE) && !done_d;
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = parity_d;
`endif
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
